// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes assembler records into 32-bit words and streams them plus a halt word into imem
module instr_encoder_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inLast,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imemWe,
  output logic [ADDR_W-1:0] imemAddr,
  output logic [31:0]       imemData,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HALTW, S_DONE} state_e;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_e;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] SLOT_A = ADDR_W'(BASE + DEPTH - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [31:0] data_q, data_d, word;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic accept;
  fmt_e fmt;
  logic [6:0] op, f7;
  logic [2:0] f3;
  always_comb begin
    fmt = F_X;
    op = 7'h33;
    f3 = 3'd0;
    f7 = 7'h00;
    case (mnem)
      5'd0:  begin fmt = F_R; f3 = 3'd1; f7 = 7'h20; end
      5'd1:  begin fmt = F_R; f3 = 3'd7; end
      5'd2:  begin fmt = F_R; f3 = 3'd3; end
      5'd3:  begin fmt = F_R; f3 = 3'd5; end
      5'd4:  begin fmt = F_R; f3 = 3'd0; end
      5'd5:  begin fmt = F_R; f3 = 3'd4; end
      5'd6:  begin fmt = F_R; f3 = 3'd2; end
      5'd7:  begin fmt = F_R; f3 = 3'd6; end
      5'd8:  begin fmt = F_I; op = 7'h13; f3 = 3'd0; end
      5'd9:  begin fmt = F_I; op = 7'h1B; f3 = 3'd6; end
      5'd10: begin fmt = F_I; op = 7'h67; f3 = 3'd0; end
      5'd11: begin fmt = F_I; op = 7'h03; f3 = 3'd2; end
      5'd12: begin fmt = F_I; op = 7'h03; f3 = 3'd0; end
      5'd13: begin fmt = F_I; op = 7'h13; f3 = 3'd7; end
      5'd14: begin fmt = F_B; op = 7'h63; f3 = 3'd0; end
      5'd15: begin fmt = F_B; op = 7'h63; f3 = 3'd1; end
      5'd16: begin fmt = F_J; op = 7'h6F; end
      5'd17: begin fmt = F_U; op = 7'h38; end
      5'd18: begin fmt = F_S; op = 7'h23; f3 = 3'd0; end
      5'd19: begin fmt = F_S; op = 7'h23; f3 = 3'd2; end
      default: fmt = F_X;
    endcase
  end
  always_comb begin
    word = 32'h0;
    case (fmt)
      F_R: word = {f7, rs2, rs1, f3, rd, op};
      F_I: word = {imm[11:0], rs1, f3, rd, op};
      F_S: word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      F_B: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      F_U: word = {imm[31:12], rd, op};
      F_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: word = 32'h0;
    endcase
  end
  assign inReady = state_q == S_LOAD;
  assign accept  = inValid & inReady;
  // done/busy lag the state by one cycle so done rises just after the halt write lands
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    we_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    err_d = err_q;
    done_d = start ? 1'b0 : state_q == S_DONE;
    busy_d = start | state_q == S_LOAD | state_q == S_HALTW;
    if (accept) begin
      if (fmt == F_X) begin
        err_d = 1'b1;
        state_d = inLast ? S_HALTW : state_q;
      end else if (!inLast && ptr_q == SLOT_A) begin
        we_d = 1'b1;
        addr_d = ptr_q;
        data_d = 32'h0;
        err_d = 1'b1;
        state_d = S_DONE;
      end else begin
        we_d = 1'b1;
        addr_d = ptr_q;
        data_d = word;
        ptr_d = ptr_q + 1'b1;
        state_d = inLast ? S_HALTW : state_q;
      end
    end
    if (state_q == S_HALTW && !start) begin
      we_d = 1'b1;
      addr_d = ptr_q;
      data_d = 32'h0;
      state_d = S_DONE;
    end
    if (start) begin
      state_d = S_LOAD;
      ptr_d = BASE_A;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q <= BASE_A;
      we_q <= 1'b0;
      addr_q <= BASE_A;
      data_q <= 32'h0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign imemWe = we_q;
  assign imemAddr = addr_q;
  assign imemData = data_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, handshake timing, halt, overflow, abort and reset
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  logic reset, start, inValid, inLast;
  logic [4:0] mnem, rd, rs1, rs2;
  logic [31:0] imm;
  logic inReady, imemWe, busy, done, error;
  logic [5:0] imemAddr;
  logic [31:0] imemData;
  logic inReady1, imemWe1, busy1, done1, error1;
  logic [5:0] imemAddr1;
  logic [31:0] imemData1;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  instr_encoder_loader #(.ADDR_W(6), .DEPTH(64), .BASE(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .inValid(inValid), .inReady(inReady),
    .inLast(inLast), .mnem(mnem), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imemWe(imemWe), .imemAddr(imemAddr), .imemData(imemData),
    .busy(busy), .done(done), .error(error)
  );
  instr_encoder_loader #(.ADDR_W(6), .DEPTH(4), .BASE(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .inValid(inValid), .inReady(inReady1),
    .inLast(inLast), .mnem(mnem), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imemWe(imemWe1), .imemAddr(imemAddr1), .imemData(imemData1),
    .busy(busy1), .done(done1), .error(error1)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rec(input logic [4:0] m, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] i, input logic last);
    inValid = 1'b1;
    mnem = m;
    rd = d;
    rs1 = s1;
    rs2 = s2;
    imm = i;
    inLast = last;
  endtask
  task automatic wr(input string tag, input logic [5:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, imemWe}, 32'd1);
    chk({tag, "_addr"}, {26'd0, imemAddr}, {26'd0, a});
    chk({tag, "_data"}, imemData, d);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
    mnem = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_we", {31'd0, imemWe}, 32'd0);
    chk("rst_addr", {26'd0, imemAddr}, 32'd0);
    chk("rst_data", imemData, 32'd0);
    chk("rst_flags", {28'd0, inReady, busy, done, error}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_ready", {31'd0, inReady}, 32'd1);
    rec(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    tick();
    inValid = 1'b0;
    wr("t1_addw", 6'd0, 32'h403110B3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick();
    wr("t1_halt", 6'd1, 32'h0);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    tick();
    chk("t1_done", {30'd0, busy, done}, 32'b01);
    chk("t1_we_off", {31'd0, imemWe}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    rec(5'd8, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    tick();
    wr("t2_addiw", 6'd0, 32'hFFF00293);
    rec(5'd14, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    tick();
    inValid = 1'b0;
    wr("t2_beq", 6'd1, 32'h00208463);
    tick();
    wr("t2_halt", 6'd2, 32'h0);
    tick();
    chk("t2_done", {30'd0, done, error}, 32'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    rec(5'd25, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    tick();
    chk("t3_inv_nowe", {31'd0, imemWe}, 32'd0);
    chk("t3_inv_err", {31'd0, error}, 32'd1);
    rec(5'd19, 5'd0, 5'd2, 5'd2, 32'd4, 1'b1);
    tick();
    inValid = 1'b0;
    wr("t3_sw", 6'd0, 32'h00212223);
    tick();
    wr("t3_halt", 6'd1, 32'h0);
    tick();
    chk("t3_done_err", {30'd0, done, error}, 32'b11);
    start = 1'b1;
    tick();
    start = 1'b0;
    rec(5'd17, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b0);
    tick();
    chk("t4_lui", imemData1, 32'h123451B8);
    chk("t4_lui_a", {26'd0, imemAddr1}, 32'd0);
    rec(5'd16, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0);
    tick();
    chk("t4_jal", imemData1, 32'h001000EF);
    chk("t4_jal_a", {26'd0, imemAddr1}, 32'd1);
    rec(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tick();
    chk("t4_addw_a", {26'd0, imemAddr1}, 32'd2);
    rec(5'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tick();
    chk("t4_ovf_we", {31'd0, imemWe1}, 32'd1);
    chk("t4_ovf_a", {26'd0, imemAddr1}, 32'd3);
    chk("t4_ovf_d", imemData1, 32'h0);
    chk("t4_ovf_err", {30'd0, error1, inReady1}, 32'b10);
    wr("t4_big_and", 6'd3, 32'h003170B3);
    rec(5'd13, 5'd1, 5'd2, 5'd0, 32'h000007FF, 1'b0);
    tick();
    inValid = 1'b0;
    chk("t4_ovf_nowe", {31'd0, imemWe1}, 32'd0);
    chk("t4_ovf_done", {29'd0, done1, busy1, inReady1}, 32'b100);
    wr("t4_big_ori", 6'd4, 32'h7FF17093);
    start = 1'b1;
    tick();
    start = 1'b0;
    rec(5'd20, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tick();
    chk("t5_inv_err", {30'd0, error, imemWe}, 32'b10);
    rec(5'd7, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tick();
    inValid = 1'b0;
    start = 1'b1;
    wr("t5_sub", 6'd0, 32'h003160B3);
    tick();
    start = 1'b0;
    chk("t5_abort", {29'd0, error, imemWe, inReady}, 32'b001);
    rec(5'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    tick();
    inValid = 1'b0;
    wr("t5_or_base", 6'd0, 32'h003150B3);
    tick();
    wr("t5_halt", 6'd1, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    rec(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inValid = 1'b0;
    chk("t6_we", {31'd0, imemWe}, 32'd0);
    chk("t6_addr", {26'd0, imemAddr}, 32'd0);
    chk("t6_data", imemData, 32'd0);
    chk("t6_flags", {28'd0, inReady, busy, done, error}, 32'd0);
    tick();
    chk("t6_idle", {27'd0, imemWe, inReady, busy, done, error}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
